// File: rtl/ws2812_pkg.sv
// ============================================================================
// Module      : ws2812_pkg
// Description : Shared types and default timing for the WS2812 stream serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ws2812_pkg;

    localparam int GRB_W = 24;

    localparam int DEF_NUM_PIXELS = 64;
    localparam int DEF_T0H_CYC    = 4;
    localparam int DEF_T1H_CYC    = 8;
    localparam int DEF_TBIT_CYC   = 15;
    localparam int DEF_TRESET_CYC = 1000;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_PIX = 3'd1,
        ST_BIT_HIGH = 3'd2,
        ST_BIT_LOW  = 3'd3,
        ST_LATCH    = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    // Scales each colour channel down by a power of two.
    function automatic grb_t grb_dim(input grb_t pix, input logic [2:0] shift);
        grb_t res;
        res.g = pix.g >> shift;
        res.r = pix.r >> shift;
        res.b = pix.b >> shift;
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ws2812_bit_cell.sv
// ============================================================================
// Module      : ws2812_bit_cell
// Description : Emits one WS2812 bit waveform per start pulse; a start in the
//               bit_done cycle chains the next bit with no gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ws2812_bit_cell #(
    parameter int T0H_CYC  = 4,
    parameter int T1H_CYC  = 8,
    parameter int TBIT_CYC = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic bit_i,
    output logic line_o,
    output logic high_done_o,
    output logic bit_done_o
);

    localparam int CNT_W = $clog2(TBIT_CYC) + 1;

    logic             active_q, active_d;
    logic             bit_q, bit_d;
    logic             line_q, line_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] cnt_inc;

    assign high_len    = bit_q ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign bit_done_o  = active_q && (cnt_q == CNT_W'(TBIT_CYC - 1));
    assign high_done_o = line_q && (cnt_inc == high_len);
    assign line_o      = line_q;

    always_comb begin
        active_d = active_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        line_d   = line_q;
        if (start_i) begin
            active_d = 1'b1;
            bit_d    = bit_i;
            cnt_d    = '0;
            line_d   = 1'b1;
        end else if (bit_done_o) begin
            active_d = 1'b0;
            cnt_d    = '0;
            line_d   = 1'b0;
        end else if (active_q) begin
            cnt_d  = cnt_inc;
            line_d = (cnt_inc < high_len);
        end
    end

    // The line itself is a flop so the LED data pin never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            bit_q    <= 1'b0;
            line_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            bit_q    <= bit_d;
            line_q   <= line_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ws2812_stream_tx.sv
// ============================================================================
// Module      : ws2812_stream_tx
// Description : Serializes a stream of GRB pixel words onto a WS2812 data line
//               with a one-word holding register. Optional macro
//               WS2812_BRIGHTNESS_EN adds a per-frame brightness shift input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ws2812_stream_tx
    import ws2812_pkg::*;
#(
    parameter int NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int T0H_CYC    = DEF_T0H_CYC,
    parameter int T1H_CYC    = DEF_T1H_CYC,
    parameter int TBIT_CYC   = DEF_TBIT_CYC,
    parameter int TRESET_CYC = DEF_TRESET_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [GRB_W-1:0]  pix_grb,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [2:0]        brightness,
`endif
    output logic              dout,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    localparam int PIX_W = $clog2(NUM_PIXELS) + 1;
    localparam int LAT_W = $clog2(TRESET_CYC) + 1;
    localparam int BIT_W = $clog2(GRB_W) + 1;

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;

    state_t           state_q, state_d;
    logic [GRB_W-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [GRB_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [PIX_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [LAT_W-1:0] latch_cnt_q, latch_cnt_d;
    logic             underrun_q, underrun_d;

    logic             xfer;
    logic             load;
    logic             bit_start;
    logic             high_done;
    logic             bit_done;
    logic [GRB_W-1:0] load_word;

    // Assertion is immediate; release is aligned to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

`ifdef WS2812_BRIGHTNESS_EN
    logic [2:0] bri_q, bri_d;
    assign load_word = grb_dim(grb_t'(hold_q), bri_q);
`else
    assign load_word = hold_q;
`endif

    assign busy       = (state_q != ST_IDLE);
    assign pix_ready  = busy && !hold_full_q && (acc_cnt_q < PIX_W'(NUM_PIXELS));
    assign xfer       = pix_valid && pix_ready;
    assign frame_done = (state_q == ST_LATCH) && (latch_cnt_q == LAT_W'(TRESET_CYC - 1));
    assign underrun   = underrun_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        pix_cnt_d   = pix_cnt_q;
        acc_cnt_d   = acc_cnt_q + PIX_W'(xfer);
        latch_cnt_d = latch_cnt_q;
        underrun_d  = underrun_q;
        load        = 1'b0;
        bit_start   = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
        bri_d       = bri_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d    = ST_WAIT_PIX;
                    pix_cnt_d  = '0;
                    acc_cnt_d  = '0;
                    underrun_d = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
                    bri_d      = brightness;
`endif
                end
            end
            ST_WAIT_PIX: begin
                if (hold_full_q) begin
                    load      = 1'b1;
                    shift_d   = load_word;
                    bit_idx_d = BIT_W'(GRB_W - 1);
                    bit_start = 1'b1;
                    state_d   = ST_BIT_HIGH;
                end
            end
            ST_BIT_HIGH: begin
                if (high_done) begin
                    state_d = ST_BIT_LOW;
                end
            end
            ST_BIT_LOW: begin
                if (bit_done) begin
                    if (bit_idx_q != '0) begin
                        bit_idx_d = bit_idx_q - BIT_W'(1);
                        shift_d   = shift_q << 1;
                        bit_start = 1'b1;
                        state_d   = ST_BIT_HIGH;
                    end else if (pix_cnt_q < PIX_W'(NUM_PIXELS - 1)) begin
                        pix_cnt_d = pix_cnt_q + PIX_W'(1);
                        if (hold_full_q) begin
                            load      = 1'b1;
                            shift_d   = load_word;
                            bit_idx_d = BIT_W'(GRB_W - 1);
                            bit_start = 1'b1;
                            state_d   = ST_BIT_HIGH;
                        end else begin
                            underrun_d = 1'b1;
                            state_d    = ST_WAIT_PIX;
                        end
                    end else begin
                        latch_cnt_d = '0;
                        state_d     = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                if (frame_done) begin
                    state_d = ST_IDLE;
                end else begin
                    latch_cnt_d = latch_cnt_q + LAT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A reload and a new transfer on the same edge leave the register full.
    assign hold_full_d = (hold_full_q && !load) || xfer;
    assign hold_d      = xfer ? pix_grb : hold_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            pix_cnt_q   <= '0;
            acc_cnt_q   <= '0;
            latch_cnt_q <= '0;
            underrun_q  <= 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
            bri_q       <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            pix_cnt_q   <= pix_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            latch_cnt_q <= latch_cnt_d;
            underrun_q  <= underrun_d;
`ifdef WS2812_BRIGHTNESS_EN
            bri_q       <= bri_d;
`endif
        end
    end

    ws2812_bit_cell #(
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC)
    ) u_bit_cell (
        .clk         (clk),
        .rst_n       (rst_int_n),
        .start_i     (bit_start),
        .bit_i       (shift_d[GRB_W-1]),
        .line_o      (dout),
        .high_done_o (high_done),
        .bit_done_o  (bit_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_ws2812_stream_tx.sv
// ============================================================================
// Module      : tb_ws2812_stream_tx
// Description : Self-checking bench for ws2812_stream_tx (NUM_PIXELS=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ws2812_stream_tx;

    localparam int NP   = 2;
    localparam int T0H  = 4;
    localparam int T1H  = 8;
    localparam int TBIT = 15;
    localparam int TRST = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [23:0] pix_grb = 24'h0;
    logic        pix_ready, dout, busy, frame_done, underrun;
`ifdef WS2812_BRIGHTNESS_EN
    logic [2:0]  brightness = 3'd0;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int   rise_q[$];
    int   width_q[$];
    int   xfer_q[$];
    int   last_rise = 0;
    logic prev_dout = 1'b0;

    ws2812_stream_tx #(
        .NUM_PIXELS (NP),
        .T0H_CYC    (T0H),
        .T1H_CYC    (T1H),
        .TBIT_CYC   (TBIT),
        .TRESET_CYC (TRST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_grb     (pix_grb),
`ifdef WS2812_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .dout        (dout),
        .busy        (busy),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: rise cycle and high width of every pulse, plus handshake cycles.
    always @(negedge clk) begin
        if (dout && !prev_dout) begin
            rise_q.push_back(cyc);
            last_rise = cyc;
        end
        if (!dout && prev_dout) width_q.push_back(cyc - last_rise);
        if (pix_valid && pix_ready) xfer_q.push_back(cyc);
        prev_dout = dout;
    end

    function automatic logic [23:0] dim(input logic [23:0] w, input int s);
        logic [7:0] g, r, b;
        g = w[23:16] >> s;
        r = w[15:8] >> s;
        b = w[7:0] >> s;
        return {g, r, b};
    endfunction

    // Runs one frame and checks the line against a timing model built from the
    // observed handshake cycles.
    task automatic run_frame(input logic [23:0] w0, input logic [23:0] w1,
                             input int d0, input int d1, input bit glitch,
                             input int bri);
        logic [23:0] words[NP];
        logic [23:0] exp_bits[NP];
        int          dly[NP];
        bit          ok, got_done, fs_hi, fs_lat, pulsed;
        int          t_done, lows, hi_run, t, r0, prev_end, idx, exp_r, exp_w;
        bit          exp_un;
        int          bri_eff;

`ifdef WS2812_BRIGHTNESS_EN
        bri_eff = bri;
`else
        bri_eff = 0 * bri;
`endif
        words[0] = w0; words[1] = w1;
        dly[0] = d0;   dly[1] = d1;
        for (int k = 0; k < NP; k++) exp_bits[k] = dim(words[k], bri_eff);

        rise_q.delete(); width_q.delete(); xfer_q.delete();
        @(posedge clk); #1;
`ifdef WS2812_BRIGHTNESS_EN
        brightness = 3'(bri);
`endif
        frame_start = 1'b1;
        pix_valid = 1'b0;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_cleared: got %b want 0", underrun); end
        @(posedge clk); #1;

        for (int k = 0; k < NP; k++) begin
            pix_valid = 1'b0;
            repeat (dly[k]) begin @(posedge clk); #1; end
            if (k > 0 && dly[k] > 24 * TBIT + 5) begin
                @(negedge clk);
                checks++;
                if (dout !== 1'b0) begin errors++; $display("FAIL stall_line_low: got %b want 0", dout); end
                checks++;
                if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_in_stall: got %b want 1", underrun); end
                @(posedge clk); #1;
            end
            pix_valid = 1'b1;
            pix_grb = words[k];
            ok = 1'b0;
            for (int n = 0; n < 4000 && !ok; n++) begin
                @(negedge clk);
                ok = pix_ready;
                @(posedge clk); #1;
            end
            checks++;
            if (!ok) begin errors++; $display("FAIL accept_timeout: pixel %0d got no ready, want ready", k); end
        end
        pix_grb = 24'($urandom);

        got_done = 1'b0; fs_hi = 1'b0; fs_lat = 1'b0; pulsed = 1'b0;
        lows = 0; hi_run = 0; t_done = 0;
        for (int n = 0; n < NP * 24 * TBIT + TRST + 3000 && !got_done; n++) begin
            @(negedge clk);
            if (pulsed) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL busy_during_ignored_start: got %b want 1", busy); end
                pulsed = 1'b0;
            end
            if (frame_done) begin
                got_done = 1'b1;
                t_done = cyc;
            end else begin
                lows   = dout ? 0 : lows + 1;
                hi_run = dout ? hi_run + 1 : 0;
                @(posedge clk); #1;
                frame_start = 1'b0;
                if (glitch && !fs_hi && hi_run == 1) begin
                    frame_start = 1'b1; fs_hi = 1'b1; pulsed = 1'b1;
                end else if (glitch && !fs_lat && rise_q.size() == NP * 24 && lows == 50) begin
                    frame_start = 1'b1; fs_lat = 1'b1; pulsed = 1'b1;
                end
            end
        end
        frame_start = 1'b0;
        checks++;
        if (!got_done) begin errors++; $display("FAIL frame_done_timeout: got none want pulse"); end

        @(posedge clk); #1;
        pix_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b want 0", busy); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b want 0", frame_done); end

        checks++;
        if (xfer_q.size() != NP) begin errors++; $display("FAIL transfer_count: got %0d want %0d", xfer_q.size(), NP); end
        checks++;
        if (rise_q.size() != NP * 24) begin errors++; $display("FAIL bit_count: got %0d want %0d", rise_q.size(), NP * 24); end

        prev_end = 0; exp_un = 1'b0;
        for (int k = 0; k < NP; k++) begin
            t = (k < xfer_q.size()) ? xfer_q[k] : 0;
            if (k == 0) r0 = t + 2;
            else r0 = (prev_end + 1 > t + 2) ? prev_end + 1 : t + 2;
            if (k > 0 && t >= prev_end) exp_un = 1'b1;
            for (int i = 0; i < 24; i++) begin
                idx   = k * 24 + i;
                exp_r = r0 + i * TBIT;
                exp_w = exp_bits[k][23 - i] ? T1H : T0H;
                checks++;
                if (idx >= rise_q.size() || rise_q[idx] != exp_r) begin
                    errors++;
                    $display("FAIL bit_start[%0d]: got %0d want %0d", idx,
                             (idx < rise_q.size()) ? rise_q[idx] : -1, exp_r);
                end
                checks++;
                if (idx >= width_q.size() || width_q[idx] != exp_w) begin
                    errors++;
                    $display("FAIL bit_high_width[%0d]: got %0d want %0d", idx,
                             (idx < width_q.size()) ? width_q[idx] : -1, exp_w);
                end
            end
            prev_end = r0 + 24 * TBIT - 1;
        end
        checks++;
        if (got_done && t_done != prev_end + TRST) begin
            errors++; $display("FAIL frame_done_cycle: got %0d want %0d", t_done, prev_end + TRST);
        end
        checks++;
        if (underrun !== exp_un) begin errors++; $display("FAIL underrun_flag: got %b want %b", underrun, exp_un); end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b want 0", dout); end
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", pix_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b want 0", pix_ready); end
    endtask

    task automatic test_basic_frame;
        run_frame(24'h800001, 24'h000000, 0, 0, 1'b0, 0);
    endtask

    task automatic test_underrun;
        run_frame(24'($urandom), 24'($urandom), 0, 460, 1'b0, 0);
        run_frame(24'($urandom), 24'($urandom), 3, 0, 1'b0, 0);
    endtask

    task automatic test_ignored_start;
        run_frame(24'($urandom), 24'($urandom), 0, 0, 1'b1, 0);
    endtask

    task automatic test_random_frames;
        int d1;
        for (int f = 0; f < 3; f++) begin
            d1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(365, 420))
                                             : int'($urandom_range(0, 200));
            run_frame(24'($urandom), 24'($urandom), int'($urandom_range(0, 20)), d1,
                      1'b0, int'($urandom_range(0, 7)));
        end
    endtask

    task automatic test_reset_mid_bit;
        bit seen;
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        pix_valid = 1'b1;
        pix_grb = 24'hFFFFFF;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = dout;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL reset_test_no_high: got 0 want 1"); end
        #2;
        rst_n = 1'b0;
        pix_valid = 1'b0;
        #1;
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL async_reset_dout: got %b want 0", dout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b want 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
        checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL post_reset_ready: got %b want 0", pix_ready); end
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL post_reset_dout: got %b want 0", dout); end
        run_frame(24'($urandom), 24'($urandom), 1, 2, 1'b0, 0);
    endtask

`ifdef WS2812_BRIGHTNESS_EN
    task automatic test_brightness;
        logic [23:0] got;
        run_frame(24'hFF8004, 24'($urandom), 0, 0, 1'b0, 2);
        got = 24'h0;
        for (int i = 0; i < 24; i++) begin
            got = {got[22:0], (i < width_q.size()) ? (width_q[i] == T1H) : 1'b0};
        end
        checks++;
        if (got !== 24'h3F2001) begin errors++; $display("FAIL brightness_word: got %h want 3f2001", got); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_underrun();
        test_ignored_start();
        test_random_frames();
        test_reset_mid_bit();
`ifdef WS2812_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
